mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the pipeline's instruction-fetch and data-access ports. It arbitrates between one instruction-read requester and one data read/write requester and serves each transaction from an internal word-addressed array after a programmable number of wait states. Byte-enabled writes and alignment/range errors are supported. It is the target end of the pipeline's memory interface and replaces the zero-latency combinational memory, so the pipeline can be exercised against realistic latency.

## Interface
- ADDR_W, 10: word-address bits; array depth 2^ADDR_W words of 32 bits.
- WAIT_CYCLES, 2: extra wait cycles per access; legal range 0..15.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_req  in  1  instruction-fetch request; held with i_addr until i_ack.
- i_addr  in  32  byte address of fetch.
- i_ack  out  1  one-cycle completion pulse for the fetch port.
- i_rdata  out  32  fetched word; valid with i_ack, held until next i_ack.
- i_err  out  1  error flag for the fetch port; valid with i_ack, held until next i_ack.
- d_req  in  1  data request; held with d_we/d_be/d_addr/d_wdata until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_be  in  4  write byte enables; bit n enables bits 8n+7:8n.
- d_addr  in  32  byte address of data access.
- d_wdata  in  32  write data.
- d_ack  out  1  one-cycle completion pulse for the data port.
- d_rdata  out  32  read word; valid with d_ack, held until next d_ack.
- d_err  out  1  error flag for the data port; valid with d_ack, held until next d_ack.
- busy  out  1  high while a transaction is in flight (BUSY or RESP).

## Operation
- The FSM has three states: IDLE, BUSY and RESP.
- **IDLE:** requests are sampled here only.
  - If only one req is high, that port is granted.
  - If both are high, the port not granted last time wins; last_grant resets to instruction, so the first tie goes to data.
  - The FSM latches the port, address, we, be and wdata, loads cnt = WAIT_CYCLES, and moves to BUSY.
- **BUSY:** if cnt != 0, decrement. If cnt == 0, perform the access, register the response, raise the granted ack, and move to RESP.
- **RESP:** the ack is high for exactly this cycle. The next edge returns to IDLE and drops the ack.
- **Error condition:** addr[1:0] != 0, or addr[31:ADDR_W+2] != 0.
  - On error, no array write happens, rdata for that port = 0 and err = 1.
  - Errors take the same latency as a normal access.
- **Reads:** return the full word at addr[ADDR_W+1:2]; d_be is ignored.
- **Writes:** only enabled lanes are updated. d_be = 0 is a legal no-op write that still acks. d_rdata on a write ack = 0, d_err = 0 unless an error occurred.
- **req dropped before ack:** this is a protocol violation. The latched transaction still completes and acks.
- **req still high in the IDLE cycle after RESP:** treated as a new request.
- **Array contents:** not reset; they are retained through rst_n.

## Timing
- **Reset values** (asynchronous on rst_n low): state IDLE, cnt 0, last_grant = instruction, i_ack/d_ack/i_err/d_err/busy 0, i_rdata/d_rdata 0.
- **Reset during BUSY or RESP:** the transaction is abandoned, no write occurs, and no ack is emitted after rst_n rises.
- **Latency:** with request sampled at edge E0, ack is high after edge E0+WAIT_CYCLES+1, for one cycle.
- **Throughput:** one transaction per WAIT_CYCLES+3 cycles for back-to-back requests.
- **busy:** rises after E0 and falls with ack.
- **Write commit:** the array write commits at the same edge that raises ack. A read sampled afterwards sees the new data.
- **Only one of i_ack/d_ack** is ever high in a cycle.

## Test plan
- **Reset:** assert rst_n=0 mid-run → all outputs 0 immediately. Release with no req → outputs stay 0.
- **Word write then read** (WAIT_CYCLES=2):
  - d_we=1, d_be=F, d_addr=0x10, d_wdata=0xDEADBEEF → d_ack 3 cycles after sampling edge, d_err=0.
  - Read of 0x10 → d_rdata=0xDEADBEEF with d_ack.
- **Byte-enable write:** be=4'b0010, wdata=0x0000AA00 to 0x10, then read → 0xDEADAAEF. A be=0 write leaves 0xDEADAAEF and still acks.
- **Arbitration:**
  - After reset, raise i_req (addr 0x10) and d_req (read 0x10) together → d_ack first, then i_ack WAIT_CYCLES+3 cycles later, both data 0xDEADAAEF.
  - Next simultaneous pair → i_ack first.
- **Errors:**
  - d_addr=0x13 write → d_err=1, d_rdata=0, and a later read of 0x10 is unchanged.
  - i_addr=0x00001000 (ADDR_W=10) → i_err=1, i_rdata=0.
- **Reset mid-transaction:** pulse rst_n low during BUSY of a write to 0x20 → no ack appears. A subsequent read of 0x20 returns the prior contents.

Source files
------------

// File: rtl/mem_responder_if.sv
// Pipeline-to-memory bus: one instruction-fetch port and one data port,
// each with a request/ack handshake, plus a shared busy indication.
interface mem_responder_if;
    // Instruction-fetch port
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        i_err;

    // Data read/write port
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;

    // Transaction in flight
    logic        busy;

    // Pipeline side: issues requests, receives completions
    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  i_ack, i_rdata, i_err,
        input  d_ack, d_rdata, d_err,
        input  busy
    );

    // Memory side: receives requests, returns completions
    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output i_ack, i_rdata, i_err,
        output d_ack, d_rdata, d_err,
        output busy
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates one instruction-fetch and one data
// requester, and serves each transaction from a word-addressed array after
// WAIT_CYCLES wait states. Supports byte-enabled writes and flags misaligned
// or out-of-range addresses as errors with the same latency as a real access.
module mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2    // legal range 0..15
) (
    input  logic           clk,
    input  logic           rst_n,
    mem_responder_if.slave bus
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

    // Everything the FSM needs to remember about the granted transaction
    typedef struct packed {
        port_t       port;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } xact_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    port_t       last_grant_q, last_grant_d;
    xact_t       xact_q, xact_d;

    logic        i_ack_q, i_ack_d;
    logic        i_err_q, i_err_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic        d_ack_q, d_ack_d;
    logic        d_err_q, d_err_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic [31:0]       mem [DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic              addr_err;
    logic              do_access;
    logic              mem_we;
    logic [31:0]       rd_word;

    // Address decode of the latched transaction
    assign word_idx  = xact_q.addr[ADDR_W+1:2];
    assign addr_err  = (xact_q.addr[1:0] != 2'b00) ||
                       ((xact_q.addr >> (ADDR_W + 2)) != 32'd0);
    assign do_access = (state_q == BUSY) && (cnt_q == 4'd0);
    assign mem_we    = do_access && (xact_q.port == PORT_D) && xact_q.we && !addr_err;
    assign rd_word   = mem[word_idx];

    assign bus.i_ack   = i_ack_q;
    assign bus.i_err   = i_err_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.d_err   = d_err_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.busy    = (state_q != IDLE);

    // Next-state, arbitration and response generation
    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        xact_d       = xact_q;
        i_ack_d      = 1'b0;
        d_ack_d      = 1'b0;
        i_err_d      = i_err_q;
        i_rdata_d    = i_rdata_q;
        d_err_d      = d_err_q;
        d_rdata_d    = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    // Data wins if alone, or on a tie when instruction was served last
                    if (bus.d_req && (!bus.i_req || (last_grant_q == PORT_I))) begin
                        xact_d = '{port:  PORT_D,
                                   we:    bus.d_we,
                                   be:    bus.d_be,
                                   addr:  bus.d_addr,
                                   wdata: bus.d_wdata};
                    end else begin
                        xact_d = '{port:  PORT_I,
                                   we:    1'b0,
                                   be:    4'h0,
                                   addr:  bus.i_addr,
                                   wdata: 32'h0};
                    end
                    last_grant_d = xact_d.port;
                    cnt_d        = 4'(WAIT_CYCLES);
                    state_d      = BUSY;
                end
            end

            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = RESP;
                    if (xact_q.port == PORT_D) begin
                        d_ack_d   = 1'b1;
                        d_err_d   = addr_err;
                        d_rdata_d = (addr_err || xact_q.we) ? 32'h0 : rd_word;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_err_d   = addr_err;
                        i_rdata_d = addr_err ? 32'h0 : rd_word;
                    end
                end
            end

            RESP: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched transaction and registered responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= PORT_I;
            xact_q       <= '0;
            i_ack_q      <= 1'b0;
            i_err_q      <= 1'b0;
            i_rdata_q    <= 32'h0;
            d_ack_q      <= 1'b0;
            d_err_q      <= 1'b0;
            d_rdata_q    <= 32'h0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            xact_q       <= xact_d;
            i_ack_q      <= i_ack_d;
            i_err_q      <= i_err_d;
            i_rdata_q    <= i_rdata_d;
            d_ack_q      <= d_ack_d;
            d_err_q      <= d_err_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Byte-lane array write, committed on the edge that raises d_ack
    // NOTE: the array has no reset; contents survive rst_n, and a reset forces state to IDLE so no write can fire.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (xact_q.be[b]) begin
                    mem[word_idx][8*b +: 8] <= xact_q.wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a transaction-level reference model
// (timestamps, an associative-array memory) is compared with the DUT on every
// falling clock edge, while directed and randomized stimulus exercises it.
module tb_mem_responder;

    localparam int ADDR_W = 10;
    localparam int W      = 2;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mem_responder_if bus ();

    mem_responder #(
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a transaction accepted at sampling edge n completes at
    // edge n+W+1 (ack visible for one cycle), and the responder may accept the
    // next one at edge n+W+3. Memory is a sparse map of known words.
    // ------------------------------------------------------------------
    int  cyc = 0;
    int  done_cyc = 0;
    int  free_cyc = 0;
    bit  pend = 1'b0;
    bit  last_d = 1'b0;
    bit  p_d, p_we;
    logic [3:0]  p_be;
    logic [31:0] p_addr, p_wdata;
    logic [31:0] mmem [int];

    bit          e_i_ack = 1'b0, e_d_ack = 1'b0, e_busy = 1'b0;
    bit          e_i_err = 1'b0, e_d_err = 1'b0;
    bit          e_i_known = 1'b1, e_d_known = 1'b1;
    logic [31:0] e_i_rdata = 32'h0, e_d_rdata = 32'h0;

    int          m_idx;
    bit          m_err;
    logic [31:0] m_mask;

    function automatic bit bad_addr(input logic [31:0] a);
        return ((a % 4) != 0) || (a >= (32'd4 << ADDR_W));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend      = 1'b0;
            last_d    = 1'b0;
            free_cyc  = 0;
            e_i_ack   = 1'b0;
            e_d_ack   = 1'b0;
            e_busy    = 1'b0;
            e_i_err   = 1'b0;
            e_d_err   = 1'b0;
            e_i_rdata = 32'h0;
            e_d_rdata = 32'h0;
            e_i_known = 1'b1;
            e_d_known = 1'b1;
        end else begin
            cyc++;
            e_i_ack = 1'b0;
            e_d_ack = 1'b0;
            if (pend && (cyc == done_cyc)) begin
                m_idx = (p_addr / 4) % (1 << ADDR_W);
                m_err = bad_addr(p_addr);
                if (p_d) begin
                    e_d_ack   = 1'b1;
                    e_d_err   = m_err;
                    e_d_known = 1'b1;
                    if (m_err || p_we)          e_d_rdata = 32'h0;
                    else if (mmem.exists(m_idx)) e_d_rdata = mmem[m_idx];
                    else                         e_d_known = 1'b0;
                    if (!m_err && p_we) begin
                        m_mask = 32'h0;
                        for (int b = 0; b < 4; b++)
                            if (p_be[b]) m_mask[8*b +: 8] = 8'hFF;
                        if (m_mask == 32'hFFFF_FFFF)
                            mmem[m_idx] = p_wdata;
                        else if (mmem.exists(m_idx))
                            mmem[m_idx] = (mmem[m_idx] & ~m_mask) | (p_wdata & m_mask);
                    end
                end else begin
                    e_i_ack   = 1'b1;
                    e_i_err   = m_err;
                    e_i_known = 1'b1;
                    if (m_err)                   e_i_rdata = 32'h0;
                    else if (mmem.exists(m_idx)) e_i_rdata = mmem[m_idx];
                    else                         e_i_known = 1'b0;
                end
            end
            if (pend && (cyc == done_cyc + 1)) begin
                pend     = 1'b0;
                free_cyc = cyc + 1;
            end
            if (!pend && (cyc >= free_cyc) && (bus.i_req || bus.d_req)) begin
                p_d    = bus.d_req && (!bus.i_req || !last_d);
                last_d = p_d;
                if (p_d) begin
                    p_we = bus.d_we; p_be = bus.d_be; p_addr = bus.d_addr; p_wdata = bus.d_wdata;
                end else begin
                    p_we = 1'b0; p_be = 4'h0; p_addr = bus.i_addr; p_wdata = 32'h0;
                end
                pend     = 1'b1;
                done_cyc = cyc + W + 1;
            end
            e_busy = pend;
        end
    end

    // Compare process: DUT outputs against the model on every falling edge
    always @(negedge clk) begin
        check("i_ack", 32'(bus.i_ack), 32'(e_i_ack));
        check("d_ack", 32'(bus.d_ack), 32'(e_d_ack));
        check("busy",  32'(bus.busy),  32'(e_busy));
        check("i_err", 32'(bus.i_err), 32'(e_i_err));
        check("d_err", 32'(bus.d_err), 32'(e_d_err));
        if (e_i_known) check("i_rdata", bus.i_rdata, e_i_rdata);
        if (e_d_known) check("d_rdata", bus.d_rdata, e_d_rdata);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic xfer(input bit dport, input bit we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output bit err, output int lat);
        bit seen;
        seen  = 1'b0;
        lat   = -1;
        rdata = 32'h0;
        err   = 1'b0;
        @(negedge clk);
        if (dport) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_be = be; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.i_req = 1'b1; bus.i_addr = addr;
        end
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (dport ? bus.d_ack : bus.i_ack) begin
                lat   = k - 1;
                rdata = dport ? bus.d_rdata : bus.i_rdata;
                err   = dport ? bus.d_err : bus.i_err;
                seen  = 1'b1;
                break;
            end
        end
        if (dport) bus.d_req = 1'b0;
        else       bus.i_req = 1'b0;
        check("xfer_ack_seen", 32'(seen), 32'd1);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        int r;
        a = 32'($urandom_range(0, 15)) * 32'd4;
        r = int'($urandom_range(0, 19));
        if (r == 0)      a = a + 32'($urandom_range(1, 3));
        else if (r == 1) a = a | 32'h0010_0000;
        return a;
    endfunction

    // Global time limit so the run can never hang
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [31:0] rd, rd_i, rd_d1;
    bit          er;
    int          lat;
    int          t_d1, t_i, t_d2, n_dack, n_ack;

    initial begin
        bus.i_req = 1'b0; bus.i_addr = 32'h0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0;
        bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Word write, then read back
        xfer(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, er, lat);
        check("wr_latency", 32'(lat), 32'd3);
        check("wr_err", 32'(er), 32'd0);
        check("wr_rdata", rd, 32'h0);
        xfer(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
        check("rd_latency", 32'(lat), 32'd3);
        check("rd_word", rd, 32'hDEADBEEF);

        // Asynchronous reset mid-run clears outputs at once
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_d_rdata", bus.d_rdata, 32'h0);
        check("rst_outs", {27'h0, bus.i_ack, bus.d_ack, bus.i_err, bus.d_err, bus.busy}, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_idle", {27'h0, bus.i_ack, bus.d_ack, bus.i_err, bus.d_err, bus.busy}, 32'h0);

        // Byte-enable write and zero-enable write
        xfer(1'b1, 1'b1, 4'b0010, 32'h10, 32'h0000AA00, rd, er, lat);
        xfer(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
        check("be_rd", rd, 32'hDEADAAEF);
        xfer(1'b1, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, rd, er, lat);
        check("be0_err", 32'(er), 32'd0);
        xfer(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
        check("be0_rd", rd, 32'hDEADAAEF);

        // Arbitration after reset: data wins the first tie, instruction the next
        @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h10;
        t_d1 = -1; t_i = -1; t_d2 = -1; n_dack = 0; rd_i = 32'h0; rd_d1 = 32'h0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (bus.d_ack) begin
                if (n_dack == 0) begin
                    t_d1 = k; rd_d1 = bus.d_rdata;
                end else begin
                    t_d2 = k; bus.d_req = 1'b0;
                end
                n_dack++;
            end
            if (bus.i_ack) begin
                t_i = k; rd_i = bus.i_rdata; bus.i_req = 1'b0;
            end
            if ((t_d2 >= 0) && (t_i >= 0)) break;
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        check("tie1_d_first", 32'(t_d1), 32'd4);
        check("tie1_d_data", rd_d1, 32'hDEADAAEF);
        check("tie2_i_wins_gap", 32'(t_i - t_d1), 32'd5);
        check("tie2_i_data", rd_i, 32'hDEADAAEF);
        check("tie_d_again_gap", 32'(t_d2 - t_i), 32'd5);

        // Error cases
        xfer(1'b1, 1'b1, 4'hF, 32'h13, 32'h55555555, rd, er, lat);
        check("mis_wr_err", 32'(er), 32'd1);
        check("mis_wr_rdata", rd, 32'h0);
        check("mis_wr_latency", 32'(lat), 32'd3);
        xfer(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
        check("mis_wr_unchanged", rd, 32'hDEADAAEF);
        xfer(1'b0, 1'b0, 4'h0, 32'h00001000, 32'h0, rd, er, lat);
        check("oor_i_err", 32'(er), 32'd1);
        check("oor_i_rdata", rd, 32'h0);
        xfer(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, rd, er, lat);
        check("i_fetch_ok", rd, 32'hDEADAAEF);
        check("i_fetch_err", 32'(er), 32'd0);

        // Reset during BUSY abandons a write and emits no ack
        xfer(1'b1, 1'b1, 4'hF, 32'h20, 32'h12345678, rd, er, lat);
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF;
        bus.d_addr = 32'h20; bus.d_wdata = 32'hCAFEF00D;
        @(negedge clk);
        check("busy_in_flight", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        bus.d_req = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        n_ack = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.d_ack || bus.i_ack) n_ack++;
        end
        check("no_ack_after_rst", 32'(n_ack), 32'd0);
        xfer(1'b1, 1'b0, 4'h0, 32'h20, 32'h0, rd, er, lat);
        check("rst_write_abandoned", rd, 32'h12345678);

        // Randomized traffic on both ports, checked by the model every cycle
        for (int w = 0; w < 16; w++)
            xfer(1'b1, 1'b1, 4'hF, 32'(w * 4), $urandom, rd, er, lat);
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (bus.d_ack) bus.d_req = 1'b0;
            if (bus.i_ack) bus.i_req = 1'b0;
            if (!bus.d_req && ($urandom_range(0, 2) == 0)) begin
                bus.d_req   = 1'b1;
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_be    = 4'($urandom_range(0, 15));
                bus.d_addr  = rand_addr();
                bus.d_wdata = $urandom;
            end
            if (!bus.i_req && ($urandom_range(0, 2) == 0)) begin
                bus.i_req  = 1'b1;
                bus.i_addr = rand_addr();
            end
        end
        for (int c = 0; (c < 200) && (bus.i_req || bus.d_req || bus.busy); c++) begin
            @(negedge clk);
            if (bus.d_ack) bus.d_req = 1'b0;
            if (bus.i_ack) bus.i_req = 1'b0;
        end
        check("drain_idle", {29'h0, bus.i_req, bus.d_req, bus.busy}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
